mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 24 ++
 rtl/arb_streak_cnt.sv | 41 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the memory arbiter slice.
//   - WORD_W      : width of instruction and data words
//   - AW          : default byte-address width
//   - arb_state_t : arbiter FSM states
//       IDLE   : no transaction open; requests are arbitrated here
//       BUSY_I : instruction read outstanding at the memory
//       BUSY_D : data load/store outstanding at the memory
//       RESP   : completion cycle; the owner's ready is high
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int AW     = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_streak_cnt.sv
// -----------------------------------------------------------------------------
// arb_streak_cnt
//   Counts consecutive data grants made while an instruction fetch is waiting.
//   It saturates at MAX_DSTREAK. At that point the arbiter must give the next
//   grant to the instruction side.
//
// Ports
//   clk  in   clock
//   rst  in   synchronous active-high reset, clears the count
//   inc  in   data grant while the fetch side is requesting
//   clr  in   instruction grant, or a data grant with no fetch waiting
//   sat  out  count has reached MAX_DSTREAK
// -----------------------------------------------------------------------------
module arb_streak_cnt #(
   parameter int MAX_DSTREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   // A one-bit count is still needed when MAX_DSTREAK is 0 or 1.
   localparam int CW = (MAX_DSTREAK < 2) ? 1 : $clog2(MAX_DSTREAK + 1);

   logic [CW-1:0] cnt;

   // NOTE: state registers use non-blocking assignments only. Every flop then
   // samples the values from before the edge, whatever order blocks run in.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == CW'(MAX_DSTREAK));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported unified memory between the fetch stage
//   (instruction reads) and the memory stage (loads/stores). One transaction
//   is open at a time. Data normally wins a tie. An instruction fetch that has
//   lost MAX_DSTREAK ties in a row wins the next one.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   i_req, i_addr             fetch request and word-aligned byte address
//   i_rdata, i_ready          instruction word and one-cycle completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                   memory-stage request (we=1 store, we=0 load)
//   d_rdata, d_ready          load data and one-cycle completion pulse
//   m_req, m_we, m_addr,
//   m_wdata                   registered memory command, held until m_ack
//   m_rdata, m_ack            memory read data and one-cycle completion
//   stall_f, stall_m          stage holds: request pending and not yet ready
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int AW          = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   // fetch stage
   input  logic                        i_req,
   input  logic [AW-1:0]               i_addr,
   output logic [mips_pkg::WORD_W-1:0] i_rdata,
   output logic                        i_ready,
   // memory stage
   input  logic                        d_req,
   input  logic                        d_we,
   input  logic [AW-1:0]               d_addr,
   input  logic [mips_pkg::WORD_W-1:0] d_wdata,
   output logic [mips_pkg::WORD_W-1:0] d_rdata,
   output logic                        d_ready,
   // unified memory
   output logic                        m_req,
   output logic                        m_we,
   output logic [AW-1:0]               m_addr,
   output logic [mips_pkg::WORD_W-1:0] m_wdata,
   input  logic [mips_pkg::WORD_W-1:0] m_rdata,
   input  logic                        m_ack,
   // pipeline holds
   output logic                        stall_f,
   output logic                        stall_m
);

   import mips_pkg::*;

   arb_state_t        state;
   logic [WORD_W-1:0] rsp_q;

   logic in_idle;
   logic grant_d;
   logic grant_i;
   logic streak_inc;
   logic streak_clr;
   logic streak_sat;

   // Arbitration is only evaluated in IDLE. A request seen in RESP waits one
   // cycle. Data wins unless the fetch side has been passed over too often.
   assign in_idle    = (state == IDLE);
   assign grant_d    = in_idle & d_req & ~(i_req & streak_sat);
   assign grant_i    = in_idle & i_req & ~grant_d;
   assign streak_inc = grant_d & i_req;
   assign streak_clr = grant_i | (grant_d & ~i_req);

   arb_streak_cnt #(
      .MAX_DSTREAK (MAX_DSTREAK)
   ) u_streak (
      .clk (clk),
      .rst (rst),
      .inc (streak_inc),
      .clr (streak_clr),
      .sat (streak_sat)
   );

   // The memory command, the ready pulses and the response word are all
   // registered. m_ack and m_rdata therefore never reach an output in the
   // cycle they arrive.
   // NOTE: the reset branch clears every register, including the response
   // word. Before the first transaction, the rdata outputs then read as 0
   // rather than X.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         rsp_q   <= '0;
         i_ready <= 1'b0;
         d_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state   <= BUSY_D;
                  m_req   <= 1'b1;
                  m_we    <= d_we;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
               end else if (grant_i) begin
                  state   <= BUSY_I;
                  m_req   <= 1'b1;
                  m_we    <= 1'b0;
                  m_addr  <= i_addr;
                  m_wdata <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               // The command stays frozen until the memory acknowledges it.
               // Requester activity cannot disturb an open transaction.
               if (m_ack) begin
                  state   <= RESP;
                  m_req   <= 1'b0;
                  rsp_q   <= m_rdata;
                  i_ready <= (state == BUSY_I);
                  d_ready <= (state == BUSY_D);
               end
            end
            RESP: begin
               state   <= IDLE;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Both read ports share rsp_q. Each port shows it only during its own pulse.
   assign i_rdata = i_ready ? rsp_q : '0;
   assign d_rdata = d_ready ? rsp_q : '0;

   assign stall_f = i_req & ~i_ready;
   assign stall_m = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A transaction-level model predicts
//   every output each cycle. A memory responder acknowledges the modelled
//   command after a chosen latency. Directed scenarios pin key cycles to
//   literal values, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int MAXS = 4;
   localparam int AWB  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req;
   logic [AWB-1:0]    i_addr;
   logic [31:0]       i_rdata;
   logic              i_ready;
   logic              d_req;
   logic              d_we;
   logic [AWB-1:0]    d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ready;
   logic              m_req;
   logic              m_we;
   logic [AWB-1:0]    m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_rdata;
   logic              m_ack;
   logic              stall_f;
   logic              stall_m;

   always #5 clk = ~clk;

   mem_arbiter #(
      .MAX_DSTREAK (MAXS),
      .AW          (AWB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ready (i_ready),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ready (d_ready),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .stall_f (stall_f),
      .stall_m (stall_m)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // One outstanding memory transaction at most. A completed transaction is
   // answered for one cycle. A fetch passed over MAXS times wins the next tie.
   typedef struct {
      bit          valid;
      bit          is_i;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      int          age;
   } txn_t;

   txn_t        cur;
   bit          resp_i, resp_d, resp_store;
   logic [31:0] resp_data;
   int          streak;
   logic [31:0] mem [logic [31:0]];
   bit          mem_auto, spurious_en, rand_lat, rand_mode;
   int          next_lat;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic int pick_lat();
      if (rand_lat) return int'($urandom_range(1, 4));
      return next_lat;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   task automatic model_step();
      bit take_d;
      if (rst) begin
         cur.valid = 1'b0;
         resp_i    = 1'b0;
         resp_d    = 1'b0;
         resp_data = '0;
         streak    = 0;
      end else if (resp_i || resp_d) begin
         resp_i = 1'b0;
         resp_d = 1'b0;
      end else if (cur.valid) begin
         if (m_ack) begin
            resp_data  = m_rdata;
            resp_i     = cur.is_i;
            resp_d     = !cur.is_i;
            resp_store = cur.we;
            if (cur.we) mem[cur.addr] = cur.wdata;
            cur.valid  = 1'b0;
         end
      end else begin
         take_d = d_req && !(i_req && streak >= MAXS);
         if (take_d) begin
            cur.valid = 1'b1; cur.is_i = 1'b0; cur.we = d_we;
            cur.addr = d_addr; cur.wdata = d_wdata;
            cur.lat = pick_lat(); cur.age = 0;
            streak = i_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
         end else if (i_req) begin
            cur.valid = 1'b1; cur.is_i = 1'b1; cur.we = 1'b0;
            cur.addr = i_addr; cur.wdata = '0;
            cur.lat = pick_lat(); cur.age = 0;
            streak = 0;
         end
      end
   endtask

   task automatic compare();
      check("m_req", m_req, cur.valid);
      if (cur.valid) begin
         check("m_we", m_we, cur.we);
         check("m_addr", m_addr, cur.addr);
         if (cur.we) check("m_wdata", m_wdata, cur.wdata);
      end
      check("i_ready", i_ready, resp_i);
      check("d_ready", d_ready, resp_d);
      check("i_rdata", i_rdata, resp_i ? resp_data : 32'h0);
      if (!resp_d) check("d_rdata_idle", d_rdata, 32'h0);
      else if (!resp_store) check("d_rdata", d_rdata, resp_data);
      check("stall_f", stall_f, i_req && !resp_i);
      check("stall_m", stall_m, d_req && !resp_d);
   endtask

   task automatic mem_drive();
      if (mem_auto) begin
         if (cur.valid) begin
            m_ack   = (cur.age == cur.lat);
            m_rdata = m_ack ? mem_rd(cur.addr) : $urandom;
            cur.age++;
         end else begin
            m_ack   = spurious_en && ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
         end
      end
   endtask

   task automatic rand_drive();
      rst = ($urandom_range(0, 299) == 0);
      if (i_req) begin
         if (resp_i) begin
            i_req  = ($urandom_range(0, 2) == 0);
            i_addr = rand_addr();
         end else if ($urandom_range(0, 199) == 0) begin
            i_req = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         i_req  = 1'b1;
         i_addr = rand_addr();
      end
      if (d_req) begin
         if (resp_d) begin
            d_req   = ($urandom_range(0, 2) == 0);
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = rand_addr();
            d_wdata = $urandom;
         end else if ($urandom_range(0, 199) == 0) begin
            d_req = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         d_req   = 1'b1;
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = rand_addr();
         d_wdata = $urandom;
      end
   endtask

   // One clock: update the model at the edge, compare at the falling edge,
   // then drive the next inputs.
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      mem_drive();
      if (rand_mode) rand_drive();
   endtask

   task automatic wait_ready(input bit for_i, input string name);
      int n;
      n = 0;
      while (!(for_i ? resp_i : resp_d) && n < 60) begin
         step();
         n++;
      end
      check(name, for_i ? resp_i : resp_d, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] seq;
      int         ngr, busy_ok, nready;
      bit         prev;

      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
      cur.valid = 1'b0; resp_i = 1'b0; resp_d = 1'b0; resp_store = 1'b0;
      resp_data = '0; streak = 0;
      mem_auto = 1'b1; spurious_en = 1'b0; rand_lat = 1'b0; rand_mode = 1'b0;
      next_lat = 1;
      mem[32'h10] = 32'h0000_0004;
      mem[32'h04] = 32'h2400_0001;

      // Reset state
      step(); step();
      check("rst_m_req", m_req, 1'b0);
      check("rst_m_we", m_we, 1'b0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_m_wdata", m_wdata, 32'h0);
      check("rst_i_ready", i_ready, 1'b0);
      check("rst_d_ready", d_ready, 1'b0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);

      // A request seen during reset is not granted
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      step();
      check("rst_no_grant", m_req, 1'b0);
      rst = 1'b0;

      // Single load, memory latency 1 -> ready 3 cycles after request
      step();
      check("t1_m_req", m_req, 1'b1);
      check("t1_m_addr", m_addr, 32'h10);
      step();
      check("t1_no_early_ready", d_ready, 1'b0);
      step();
      check("t1_d_ready", d_ready, 1'b1);
      check("t1_d_rdata", d_rdata, 32'h4);
      d_req = 1'b0;
      step();
      check("t1_pulse_one_cycle", d_ready, 1'b0);

      // Simultaneous requests: data store first, then the instruction fetch
      i_req = 1'b1; i_addr = 32'h4;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      step();
      check("t2_m_we", m_we, 1'b1);
      check("t2_m_addr", m_addr, 32'h20);
      check("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
      wait_ready(1'b0, "t2_d_timeout");
      check("t2_i_not_ready", i_ready, 1'b0);
      d_req = 1'b0;
      step();
      check("t2_resp_to_idle", m_req, 1'b0);
      step();
      check("t2_i_grant", m_req, 1'b1);
      check("t2_i_addr", m_addr, 32'h4);
      check("t2_i_we", m_we, 1'b0);
      wait_ready(1'b1, "t2_i_timeout");
      check("t2_i_rdata", i_rdata, 32'h2400_0001);
      i_req = 1'b0;
      step();

      // Starvation: fetch waits while data requests keep coming
      i_req = 1'b1; i_addr = 32'h8;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      seq = '0; ngr = 0; prev = m_req;
      for (int k = 0; k < 200 && ngr < 6; k++) begin
         step();
         if (m_req && !prev) begin
            seq = {seq[4:0], (m_addr != 32'h8)};
            ngr++;
         end
         prev = m_req;
         if (resp_d) d_addr = d_addr + 32'h4;
         if (resp_i) i_req = 1'b0;
      end
      check("t3_ngrants", ngr, 6);
      check("t3_grant_order", seq, 6'b111101);
      wait_ready(1'b0, "t3_d_timeout");
      d_req = 1'b0;
      i_req = 1'b0;
      step();

      // Slow memory: ack 5 cycles after m_req rises
      next_lat = 5;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
      busy_ok = 0; nready = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (m_req && m_we && m_addr == 32'h40 && m_wdata == 32'hCAFE_F00D && stall_m)
            busy_ok++;
         if (d_ready) begin
            nready++;
            d_req = 1'b0;
         end
      end
      check("t4_stable_cycles", busy_ok, 6);
      check("t4_ready_pulses", nready, 1);
      next_lat = 1;

      // Reset during BUSY_D, ack arrives afterwards
      mem_auto = 1'b0; m_ack = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
      step();
      check("t5_grant", m_req, 1'b1);
      step();
      rst = 1'b1;
      step();
      check("t5_rst_m_req", m_req, 1'b0);
      check("t5_rst_d_ready", d_ready, 1'b0);
      rst = 1'b0; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234_5678;
      step();
      check("t5_late_ack_ready", d_ready, 1'b0);
      check("t5_late_ack_m_req", m_req, 1'b0);
      m_ack = 1'b0;
      step();
      check("t5_after_ready", d_ready, 1'b0);
      d_req = 1'b1; d_addr = 32'h54;
      step();
      check("t5_idle_grant", m_req, 1'b1);
      mem_auto = 1'b1;
      wait_ready(1'b0, "t5_d_timeout");
      d_req = 1'b0;
      step();

      // Spurious ack in IDLE
      mem_auto = 1'b0; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
      step();
      check("t6_i_ready", i_ready, 1'b0);
      check("t6_d_ready", d_ready, 1'b0);
      check("t6_m_req", m_req, 1'b0);
      m_ack = 1'b0;
      step();
      check("t6_no_resp", d_ready | i_ready, 1'b0);
      i_req = 1'b1; i_addr = 32'hC;
      step();
      check("t6_idle_grant", m_req, 1'b1);
      check("t6_idle_addr", m_addr, 32'hC);
      mem_auto = 1'b1;
      wait_ready(1'b1, "t6_i_timeout");
      i_req = 1'b0;
      step();

      // Randomized traffic with random latency, spurious acks and resets
      rand_lat = 1'b1; spurious_en = 1'b1; rand_mode = 1'b1;
      repeat (3000) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
